// File: rtl/ring_phase_checker_pkg.sv
// Shared definitions for the ring phase checker.
// The package holds the state encoding, the fault codes and the ring reset pattern.
package ring_phase_checker_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_ONEHOT = 2'd1;
    localparam logic [1:0] ERR_STALL  = 2'd2;
    localparam logic [1:0] ERR_MOVE   = 2'd3;

    localparam logic [3:0] PH_RESET = 4'b0001;

    // One step of the ring: phase 3 wraps back to phase 0.
    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/onehot4_enc.sv
// Combinational 4-bit one-hot to binary encoder with a validity flag.
// If the input is not one-hot, idx is 0 and is_onehot is low.
module onehot4_enc (
    input  logic [3:0] ph,
    output logic [1:0] idx,
    output logic       is_onehot
);

    always_comb begin
        idx       = 2'd0;
        is_onehot = 1'b0;
        case (ph)
            4'b0001: begin idx = 2'd0; is_onehot = 1'b1; end
            4'b0010: begin idx = 2'd1; is_onehot = 1'b1; end
            4'b0100: begin idx = 2'd2; is_onehot = 1'b1; end
            4'b1000: begin idx = 2'd3; is_onehot = 1'b1; end
            default: begin idx = 2'd0; is_onehot = 1'b0; end
        endcase
    end

endmodule

// File: rtl/ring_phase_checker.sv
// Read-only monitor for the 4-phase ring sequencer: it checks every transition against the step request.
// It also reports the phase index and a revolution count, and it latches the first fault until clr_err.
module ring_phase_checker
    import ring_phase_checker_pkg::*;
#(
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic [3:0]       ph,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic [REV_W-1:0] rev_cnt,
    output logic             err_onehot,
    output logic             err_stall,
    output logic             err_move,
    output logic [1:0]       err_code
);

    localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);

    state_t           state, state_nxt;
    logic [3:0]       prev_ph;
    logic             prev_step;
    logic [1:0]       ph_idx;
    logic             ph_onehot;
    logic [3:0]       exp_ph;
    logic             wrap;
    logic [REV_W-1:0] rev_nxt;
    logic             onehot_nxt, stall_nxt, move_nxt;
    logic [1:0]       code_nxt;

    onehot4_enc u_enc (
        .ph        (ph),
        .idx       (ph_idx),
        .is_onehot (ph_onehot)
    );

    assign exp_ph = prev_step ? rotl4(prev_ph) : prev_ph;
    assign wrap   = prev_step && (prev_ph == 4'b1000) && (ph == PH_RESET);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= UNLOCKED;
        else          state <= state_nxt;
    end

    // Fault priority is onehot, then stall, then move; only the first fault is recorded.
    always_comb begin
        state_nxt  = state;
        rev_nxt    = rev_cnt;
        onehot_nxt = err_onehot;
        stall_nxt  = err_stall;
        move_nxt   = err_move;
        code_nxt   = err_code;
        case (state)
            UNLOCKED: begin
                if (ph == PH_RESET) begin
                    state_nxt = LOCKED;
                    rev_nxt   = '0;
                end
            end
            LOCKED: begin
                if (!ph_onehot) begin
                    onehot_nxt = 1'b1;
                    code_nxt   = ERR_ONEHOT;
                    state_nxt  = FAULT;
                end else if (prev_step && (ph == prev_ph)) begin
                    stall_nxt = 1'b1;
                    code_nxt  = ERR_STALL;
                    state_nxt = FAULT;
                end else if (ph != exp_ph) begin
                    move_nxt  = 1'b1;
                    code_nxt  = ERR_MOVE;
                    state_nxt = FAULT;
                end else if (wrap) begin
                    rev_nxt = rev_cnt + REV_ONE;
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_nxt  = UNLOCKED;
                    onehot_nxt = 1'b0;
                    stall_nxt  = 1'b0;
                    move_nxt   = 1'b0;
                    code_nxt   = ERR_NONE;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_ph    <= PH_RESET;
            prev_step  <= 1'b0;
            phase      <= 2'd0;
            locked     <= 1'b0;
            rev_cnt    <= '0;
            err_onehot <= 1'b0;
            err_stall  <= 1'b0;
            err_move   <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            prev_ph    <= ph;
            prev_step  <= step;
            if (ph_onehot) phase <= ph_idx;
            locked     <= (state_nxt == LOCKED);
            rev_cnt    <= rev_nxt;
            err_onehot <= onehot_nxt;
            err_stall  <= stall_nxt;
            err_move   <= move_nxt;
            err_code   <= code_nxt;
        end
    end

    assign phase_valid = locked;

endmodule

// File: tb/tb_ring_phase_checker.sv
// Self-checking bench for ring_phase_checker: a phase-index model checked every cycle, plus literal checkpoints.
// A second instance with REV_W=2 shares the stimulus so that revolution-counter wrapping is observed.
module tb_ring_phase_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       step = 1'b0;
    logic [3:0] ph = 4'b0001;
    logic       clr_err = 1'b0;

    logic [1:0] phase, phase2;
    logic       phase_valid, phase_valid2, locked, locked2;
    logic [7:0] rev_cnt;
    logic [1:0] rev_cnt2;
    logic       err_onehot, err_onehot2, err_stall, err_stall2, err_move, err_move2;
    logic [1:0] err_code, err_code2;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    ring_phase_checker #(.REV_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .step(step), .ph(ph), .clr_err(clr_err),
        .phase(phase), .phase_valid(phase_valid), .locked(locked), .rev_cnt(rev_cnt),
        .err_onehot(err_onehot), .err_stall(err_stall), .err_move(err_move), .err_code(err_code)
    );

    ring_phase_checker #(.REV_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .step(step), .ph(ph), .clr_err(clr_err),
        .phase(phase2), .phase_valid(phase_valid2), .locked(locked2), .rev_cnt(rev_cnt2),
        .err_onehot(err_onehot2), .err_stall(err_stall2), .err_move(err_move2), .err_code(err_code2)
    );

    always #5 clk = ~clk;

    // Model state: mode 0 unlocked, 1 locked, 2 fault; phases are plain indices 0..3.
    int         m_mode, m_phase, m_rev, m_code;
    logic [3:0] m_prev_ph;
    bit         m_prev_step, m_eo, m_es, m_em;

    function automatic int ph_index(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int         n_ones;
        int         want_idx;
        logic [3:0] want_ph;
        if (!reset_n) begin
            m_mode = 0; m_phase = 0; m_rev = 0; m_code = 0;
            m_prev_ph = 4'b0001; m_prev_step = 1'b0;
            m_eo = 1'b0; m_es = 1'b0; m_em = 1'b0;
        end else begin
            n_ones = $countones(ph);
            case (m_mode)
                0: if (ph == 4'b0001) begin m_mode = 1; m_rev = 0; end
                1: begin
                    want_idx = (ph_index(m_prev_ph) + (m_prev_step ? 1 : 0)) % 4;
                    want_ph  = 4'b0001 << want_idx;
                    if (n_ones != 1) begin
                        m_eo = 1'b1; m_code = 1; m_mode = 2;
                    end else if (m_prev_step && ph == m_prev_ph) begin
                        m_es = 1'b1; m_code = 2; m_mode = 2;
                    end else if (ph != want_ph) begin
                        m_em = 1'b1; m_code = 3; m_mode = 2;
                    end else if (m_prev_step && want_idx == 0) begin
                        m_rev = m_rev + 1;
                    end
                end
                default: if (clr_err) begin
                    m_eo = 1'b0; m_es = 1'b0; m_em = 1'b0; m_code = 0; m_mode = 0;
                end
            endcase
            if (n_ones == 1) m_phase = ph_index(ph);
            m_prev_ph = ph;
            m_prev_step = step;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] p, input logic c);
        step = s;
        ph = p;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("phase", 32'(phase), 32'(m_phase));
            checkOutput("locked", 32'(locked), 32'(m_mode == 1));
            checkOutput("phase_valid", 32'(phase_valid), 32'(m_mode == 1));
            checkOutput("rev_cnt", 32'(rev_cnt), 32'(m_rev % 256));
            checkOutput("err_onehot", 32'(err_onehot), 32'(m_eo));
            checkOutput("err_stall", 32'(err_stall), 32'(m_es));
            checkOutput("err_move", 32'(err_move), 32'(m_em));
            checkOutput("err_code", 32'(err_code), 32'(m_code));
            checkOutput("rev_cnt_w2", 32'(rev_cnt2), 32'(m_rev % 4));
            checkOutput("locked_w2", 32'(locked2), 32'(m_mode == 1));
            checkOutput("err_code_w2", 32'(err_code2), 32'(m_code));
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_phase"}, 32'(phase), 0);
        checkOutput({tag, "_valid"}, 32'(phase_valid), 0);
        checkOutput({tag, "_locked"}, 32'(locked), 0);
        checkOutput({tag, "_rev"}, 32'(rev_cnt), 0);
        checkOutput({tag, "_flags"}, {29'd0, err_onehot, err_stall, err_move}, 0);
        checkOutput({tag, "_code"}, 32'(err_code), 0);
        checkOutput({tag, "_rev_w2"}, 32'(rev_cnt2), 0);
        checkOutput({tag, "_code_w2"}, 32'(err_code2), 0);
    endtask

    initial begin
        int         wrap_w2 [5] = '{1, 2, 3, 0, 1};
        logic [3:0] v;

        #1 reset_n = 1'b0;
        #1 checkResetValues("reset");
        check_en = 1'b1;
        #10 reset_n = 1'b1;

        // Lock, then eight back-to-back steps: two full revolutions.
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("lock_locked", 32'(locked), 1);
        for (int k = 0; k < 8; k++) begin
            v = 4'b0001 << (k % 4);
            applyStimulus(1'b1, v, 1'b0);
            checkOutput("rot_phase", 32'(phase), 32'(k % 4));
        end
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("rot_rev", 32'(rev_cnt), 2);
        checkOutput("rot_phase_end", 32'(phase), 0);
        checkOutput("rot_code", 32'(err_code), 0);

        // Stall: step issued but ph held.
        applyStimulus(1'b1, 4'b0001, 1'b0);
        applyStimulus(1'b1, 4'b0010, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("stall_flag", 32'(err_stall), 1);
        checkOutput("stall_code", 32'(err_code), 2);
        checkOutput("stall_locked", 32'(locked), 0);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("stall_clr_flag", 32'(err_stall), 0);
        checkOutput("stall_clr_code", 32'(err_code), 0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("unlocked_wait", 32'(locked), 0);

        // Move without a step, then clear and relock.
        applyStimulus(1'b0, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("move_flag", 32'(err_move), 1);
        checkOutput("move_code", 32'(err_code), 3);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("move_clr", 32'(err_move), 0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("relock", 32'(locked), 1);
        checkOutput("relock_rev", 32'(rev_cnt), 0);

        // Non-one-hot ph; the first fault class sticks.
        applyStimulus(1'b0, 4'b0110, 1'b0);
        checkOutput("onehot_flag", 32'(err_onehot), 1);
        checkOutput("onehot_code", 32'(err_code), 1);
        checkOutput("onehot_phase_hold", 32'(phase), 0);
        applyStimulus(1'b1, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("sticky_code", 32'(err_code), 1);
        checkOutput("sticky_stall", 32'(err_stall), 0);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("fault_beats_clr", 32'(locked), 0);
        checkOutput("fault_beats_clr_code", 32'(err_code), 1);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("still_fault", 32'(locked), 0);
        applyStimulus(1'b0, 4'b0001, 1'b1);

        // Five revolutions; the 2-bit counter wraps.
        applyStimulus(1'b0, 4'b0001, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            v = 4'b0001 << (k % 4);
            applyStimulus(k < 20, v, 1'b0);
            if (k > 0 && k % 4 == 0) begin
                checkOutput("wrap_w2", 32'(rev_cnt2), 32'(wrap_w2[k / 4 - 1]));
                checkOutput("wrap_w8", 32'(rev_cnt), 32'(k / 4));
            end
        end

        // Asynchronous reset while in FAULT.
        applyStimulus(1'b1, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("pre_reset_stall", 32'(err_stall), 1);
        #2 reset_n = 1'b0;
        #1 checkResetValues("async");
        @(negedge clk);
        #2 reset_n = 1'b1;
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("post_reset_lock", 32'(locked), 1);

        check_en = 1'b0;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
